// File: rtl/div_pkg.sv
// Shared constants for the radix-2 restoring divider: FSM states, flag
// encodings and the default operand width.
package div_pkg;

    typedef enum logic [1:0] {
        DIV_FREE    = 2'd0,
        DIV_BY_ZERO = 2'd1,
        DIV_ON      = 2'd2,
        DIV_END     = 2'd3
    } div_state_e;

    localparam logic DIV_RESULT_READY     = 1'b1;
    localparam logic DIV_RESULT_NOT_READY = 1'b0;
    localparam logic DIV_START            = 1'b1;
    localparam logic DIV_STOP             = 1'b0;

    localparam int DEFAULT_WIDTH = 32;

endpackage

// File: rtl/div.sv
// Multi-cycle DIV/DIVU unit for the execute stage: radix-2 restoring division,
// one quotient bit per clock, result returned as {remainder, quotient}.
module div
    import div_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               signed_div_i,
    input  logic [WIDTH-1:0]   opdata1_i,
    input  logic [WIDTH-1:0]   opdata2_i,
    input  logic               start_i,
    input  logic               annul_i,
    output logic [2*WIDTH-1:0] result_o,
    output logic               ready_o,
    output div_state_e         dbg_state
);

    localparam int CW = $clog2(WIDTH);

    // Handshake: EX raises start_i and holds it (with operands valid on the
    // accepting edge) until it sees ready_o; result_o is valid only while
    // ready_o=1 and stays stable until start_i drops, which releases the unit.

    div_state_e state, state_nxt;

    logic [WIDTH-1:0]   dividend_q;
    logic [WIDTH-1:0]   divisor_q;
    logic [WIDTH-1:0]   rem_q;
    logic [CW-1:0]      cnt;
    logic               neg_quot;
    logic               neg_rem;

    logic               accept;
    logic               divisor_zero;
    logic               last_iter;
    logic [WIDTH-1:0]   op1_abs;
    logic [WIDTH-1:0]   op2_abs;
    logic [WIDTH:0]     trial;
    logic [WIDTH:0]     diff;
    logic               qbit;
    logic [WIDTH-1:0]   rem_nxt;
    logic [WIDTH-1:0]   quot_nxt;
    logic [WIDTH-1:0]   quot_fix;
    logic [WIDTH-1:0]   rem_fix;
    logic               ready_d;
    logic [2*WIDTH-1:0] result_d;

    assign accept       = (start_i == DIV_START) && !annul_i;
    assign divisor_zero = (opdata2_i == '0);
    assign last_iter    = (cnt == CW'(WIDTH - 1));

    assign op1_abs = (signed_div_i && opdata1_i[WIDTH-1]) ? ('0 - opdata1_i) : opdata1_i;
    assign op2_abs = (signed_div_i && opdata2_i[WIDTH-1]) ? ('0 - opdata2_i) : opdata2_i;

    // The dividend register doubles as the quotient: its MSB feeds the
    // partial remainder while each new quotient bit enters at the LSB.
    assign trial    = {rem_q, dividend_q[WIDTH-1]};
    assign diff     = trial - {1'b0, divisor_q};
    assign qbit     = ~diff[WIDTH];
    assign rem_nxt  = qbit ? diff[WIDTH-1:0] : trial[WIDTH-1:0];
    assign quot_nxt = {dividend_q[WIDTH-2:0], qbit};
    assign quot_fix = neg_quot ? ('0 - quot_nxt) : quot_nxt;
    assign rem_fix  = neg_rem  ? ('0 - rem_nxt)  : rem_nxt;

    assign dbg_state = state;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= DIV_FREE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            DIV_FREE: begin
                if (accept) begin
                    state_nxt = divisor_zero ? DIV_BY_ZERO : DIV_ON;
                end
            end
            DIV_BY_ZERO: state_nxt = DIV_END;
            DIV_ON: begin
                if (annul_i) begin
                    state_nxt = DIV_FREE;
                end else if (last_iter) begin
                    state_nxt = DIV_END;
                end
            end
            DIV_END: begin
                if (start_i == DIV_STOP) begin
                    state_nxt = DIV_FREE;
                end
            end
            default: state_nxt = DIV_FREE;
        endcase
    end

    always_comb begin
        ready_d  = ready_o;
        result_d = result_o;
        unique case (state)
            DIV_FREE: begin
                ready_d  = DIV_RESULT_NOT_READY;
                result_d = '0;
            end
            DIV_BY_ZERO: begin
                ready_d  = DIV_RESULT_READY;
                result_d = '0;
            end
            DIV_ON: begin
                if (!annul_i && last_iter) begin
                    ready_d  = DIV_RESULT_READY;
                    result_d = {rem_fix, quot_fix};
                end else begin
                    ready_d  = DIV_RESULT_NOT_READY;
                    result_d = '0;
                end
            end
            DIV_END: begin
                if (start_i == DIV_STOP) begin
                    ready_d  = DIV_RESULT_NOT_READY;
                    result_d = '0;
                end
            end
            default: begin
                ready_d  = DIV_RESULT_NOT_READY;
                result_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ready_o  <= DIV_RESULT_NOT_READY;
            result_o <= '0;
        end else begin
            ready_o  <= ready_d;
            result_o <= result_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dividend_q <= '0;
            divisor_q  <= '0;
            rem_q      <= '0;
            cnt        <= '0;
            neg_quot   <= 1'b0;
            neg_rem    <= 1'b0;
        end else if (state == DIV_FREE && accept && !divisor_zero) begin
            dividend_q <= op1_abs;
            divisor_q  <= op2_abs;
            rem_q      <= '0;
            cnt        <= '0;
            neg_quot   <= signed_div_i && (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
            neg_rem    <= signed_div_i && opdata1_i[WIDTH-1];
        end else if (state == DIV_ON && !annul_i) begin
            dividend_q <= quot_nxt;
            rem_q      <= rem_nxt;
            cnt        <= cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_div.sv
// Directed self-checking bench for div: arithmetic reference model, expected
// queue of results and a per-cycle output compare process.
module tb_div;
    import div_pkg::*;

    logic        clk;
    logic        rst;
    logic        signed_div;
    logic [31:0] opdata1;
    logic [31:0] opdata2;
    logic        start;
    logic        annul;
    logic [63:0] result;
    logic        ready;
    div_state_e  dbg_state;

    int total = 0;
    int bad   = 0;
    logic [63:0] exp_q[$];
    logic [63:0] cur_exp = '0;
    logic        prev_ready = 1'b0;

    div #(.WIDTH(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (signed_div),
        .opdata1_i    (opdata1),
        .opdata2_i    (opdata2),
        .start_i      (start),
        .annul_i      (annul),
        .result_o     (result),
        .ready_o      (ready),
        .dbg_state    (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input bit ok, input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, req);
        end
    endtask

    // Reference: plain integer arithmetic in 64 bits, truncating division.
    function automatic logic [63:0] model(input bit sd, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        if (b == 32'd0) return 64'd0;
        if (sd) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = longint'({32'd0, a});
            sb = longint'({32'd0, b});
        end
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    // Output compare: every cycle out of reset, result must be 0 when not
    // ready and equal the oldest expected value while ready.
    always @(negedge clk) begin
        if (!rst) begin
            prev_ready = 1'b0;
        end else begin
            if (ready) begin
                if (!prev_ready) begin
                    if (exp_q.size() == 0) begin
                        check(1'b0, "unexpected_ready", result, 64'd0);
                    end else begin
                        cur_exp = exp_q.pop_front();
                    end
                end
                check(result == cur_exp, "result", result, cur_exp);
            end else begin
                check(result == 64'd0, "idle_result", result, 64'd0);
            end
            prev_ready = ready;
        end
    end

    task automatic run_op(input bit sd, input logic [31:0] a, input logic [31:0] b);
        int lat;
        lat = (b == 32'd0) ? 1 : 32;
        exp_q.push_back(model(sd, a, b));
        signed_div = sd;
        opdata1    = a;
        opdata2    = b;
        start      = 1'b1;
        @(posedge clk);
        #1;
        opdata1 = $urandom_range(32'hFFFF_FFFF, 0);
        opdata2 = $urandom_range(32'hFFFF_FFFF, 0);
        repeat (lat - 1) @(posedge clk);
        @(negedge clk);
        check(ready == 1'b0, "early_ready", {63'd0, ready}, 64'd0);
        @(posedge clk);
        @(negedge clk);
        check(ready == 1'b1, "latency", {63'd0, ready}, 64'd1);
        repeat (2) @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check(ready == 1'b0, "drop_ready", {63'd0, ready}, 64'd0);
        check(dbg_state == DIV_FREE, "drop_state", {62'd0, dbg_state}, {62'd0, DIV_FREE});
    endtask

    initial begin
        int seen_ready;
        rst = 1'b0; signed_div = 1'b0; opdata1 = '0; opdata2 = '0; start = 1'b0; annul = 1'b0;

        check(model(0, 32'd100, 32'd7) == 64'h00000002_0000000E, "model_divu", model(0, 32'd100, 32'd7), 64'h00000002_0000000E);
        check(model(1, 32'hFFFFFFF9, 32'd2) == 64'hFFFFFFFF_FFFFFFFD, "model_neg_dividend", model(1, 32'hFFFFFFF9, 32'd2), 64'hFFFFFFFF_FFFFFFFD);
        check(model(1, 32'd7, 32'hFFFFFFFE) == 64'h00000001_FFFFFFFD, "model_neg_divisor", model(1, 32'd7, 32'hFFFFFFFE), 64'h00000001_FFFFFFFD);
        check(model(1, 32'h80000000, 32'hFFFFFFFF) == 64'h00000000_80000000, "model_overflow", model(1, 32'h80000000, 32'hFFFFFFFF), 64'h00000000_80000000);
        check(model(0, 32'h80000000, 32'hFFFFFFFF) == 64'h80000000_00000000, "model_overflow_u", model(0, 32'h80000000, 32'hFFFFFFFF), 64'h80000000_00000000);
        check(model(0, 32'd5, 32'd0) == 64'd0, "model_div0", model(0, 32'd5, 32'd0), 64'd0);

        #12;
        check(ready == 1'b0, "reset_ready", {63'd0, ready}, 64'd0);
        check(result == 64'd0, "reset_result", result, 64'd0);
        check(dbg_state == DIV_FREE, "reset_state", {62'd0, dbg_state}, {62'd0, DIV_FREE});
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        run_op(0, 32'd100, 32'd7);
        run_op(1, 32'hFFFFFFF9, 32'd2);
        run_op(1, 32'd7, 32'hFFFFFFFE);
        run_op(1, 32'h80000000, 32'hFFFFFFFF);
        run_op(0, 32'h80000000, 32'hFFFFFFFF);
        run_op(0, 32'd5, 32'd0);
        run_op(1, 32'hFFFFFF9C, 32'hFFFFFFF9);
        run_op(0, 32'hDEADBEEF, 32'h00001234);

        // annul together with start in idle must block acceptance
        @(negedge clk);
        signed_div = 1'b0; opdata1 = 32'd50; opdata2 = 32'd5; start = 1'b1; annul = 1'b1;
        repeat (3) @(negedge clk);
        check(dbg_state == DIV_FREE, "annul_blocks_accept", {62'd0, dbg_state}, {62'd0, DIV_FREE});
        start = 1'b0; annul = 1'b0;

        // annul at iteration 10
        @(negedge clk);
        opdata1 = 32'hFFFFFFFF; opdata2 = 32'd3; start = 1'b1;
        @(posedge clk);
        repeat (9) @(posedge clk);
        #1 annul = 1'b1;
        @(posedge clk);
        #1 annul = 1'b0; start = 1'b0;
        @(negedge clk);
        check(dbg_state == DIV_FREE, "annul_state", {62'd0, dbg_state}, {62'd0, DIV_FREE});
        seen_ready = 0;
        repeat (40) begin
            @(negedge clk);
            if (ready) seen_ready++;
        end
        check(seen_ready == 0, "annul_no_ready", 64'(seen_ready), 64'd0);
        run_op(0, 32'd9, 32'd3);

        // async reset mid-iteration
        @(negedge clk);
        opdata1 = 32'd1000; opdata2 = 32'd3; start = 1'b1;
        @(posedge clk);
        repeat (5) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        check(ready == 1'b0, "rst_mid_ready", {63'd0, ready}, 64'd0);
        check(result == 64'd0, "rst_mid_result", result, 64'd0);
        check(dbg_state == DIV_FREE, "rst_mid_state", {62'd0, dbg_state}, {62'd0, DIV_FREE});
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;

        // async reset while a result is being held
        @(negedge clk);
        exp_q.push_back(model(0, 32'd77, 32'd10));
        opdata1 = 32'd77; opdata2 = 32'd10; start = 1'b1;
        repeat (33) @(posedge clk);
        @(negedge clk);
        check(ready == 1'b1, "held_ready", {63'd0, ready}, 64'd1);
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        check(ready == 1'b0, "rst_end_ready", {63'd0, ready}, 64'd0);
        check(result == 64'd0, "rst_end_result", result, 64'd0);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // first start after reset release is accepted right away
        run_op(1, 32'hFFFFFF85, 32'd10);

        repeat (3) @(negedge clk);
        check(exp_q.size() == 0, "queue_drain", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
